// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through, write-allocate cache controller.
// Tag/valid/LRU state lives in flops and data in a word array. A fill engine
// streams a block from memory on a miss, and saturating counters track hits and misses.
module assoc_cache_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - 1 - OFFSET_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int DIDX_W = 1 + INDEX_W + OFFSET_W;

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t state_r, state_s;

  logic [TAG_W-1:0]    tag_r   [2][SETS];
  logic [SETS-1:0]     valid_r [2];
  logic [SETS-1:0]     lru_r;
  logic [DATA_W-1:0]   data_r  [2**DIDX_W];

  logic                victim_r;
  logic [INDEX_W-1:0]  fill_index_r;
  logic [TAG_W-1:0]    fill_tag_r;
  logic [OFFSET_W:0]   issue_cnt_r;
  logic [OFFSET_W-1:0] return_cnt_r;
  logic [CNT_W-1:0]    hit_cnt_r;
  logic [CNT_W-1:0]    miss_cnt_r;

  logic [OFFSET_W-1:0] offset_s;
  logic [INDEX_W-1:0]  index_s;
  logic [TAG_W-1:0]    tag_s;
  logic                hit0_s, hit1_s, hit_s;
  logic                hit_req_s, miss_req_s;
  logic                victim_s;
  logic                issuing_s, fill_ret_s, fill_done_s;
  logic [ADDR_W-1:0]   fill_addr_s;
  logic [DATA_W-1:0]   hit_word_s;

  assign offset_s = cpu_addr[OFFSET_W:1];
  assign index_s  = cpu_addr[OFFSET_W+INDEX_W:OFFSET_W+1];
  assign tag_s    = cpu_addr[ADDR_W-1:OFFSET_W+INDEX_W+1];

  assign hit0_s = valid_r[0][index_s] && (tag_r[0][index_s] == tag_s);
  assign hit1_s = valid_r[1][index_s] && (tag_r[1][index_s] == tag_s);
  assign hit_s  = hit0_s || hit1_s;

  assign hit_req_s  = (state_r == IDLE) && cpu_req && hit_s;
  assign miss_req_s = (state_r == IDLE) && cpu_req && !hit_s;

  // Fill invalid ways first (way 0 before way 1), otherwise evict the LRU way.
  assign victim_s = !valid_r[0][index_s] ? 1'b0 :
                    !valid_r[1][index_s] ? 1'b1 : lru_r[index_s];

  // Issue counter MSB set means all block reads have been requested.
  assign issuing_s   = (state_r == FILL) && !issue_cnt_r[OFFSET_W];
  assign fill_ret_s  = (state_r == FILL) && mem_data_valid;
  assign fill_done_s = fill_ret_s && (return_cnt_r == OFFSET_W'(WORDS - 1));
  assign fill_addr_s = {fill_tag_r, fill_index_r, issue_cnt_r[OFFSET_W-1:0], 1'b0};
  assign hit_word_s  = data_r[{hit1_s, index_s, offset_s}];

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic: a miss starts a fill, the last return ends it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (miss_req_s)  state_s = FILL; else state_s = IDLE;
      FILL:    if (fill_done_s) state_s = IDLE; else state_s = FILL;
      default: state_s = IDLE;
    endcase
  end

  // Output logic: hits complete combinationally, the fill streams word reads.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_r)
      IDLE: begin
        if (hit_req_s) begin
          cpu_ready = 1'b1;
          if (cpu_wr) begin
            mem_wr_en = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
          end else begin
            cpu_rdata = hit_word_s;
          end
        end else begin
          cpu_ready = 1'b0;
        end
      end
      FILL: begin
        if (issuing_s) begin
          mem_rd_en = 1'b1;
          mem_addr  = fill_addr_s;
        end else begin
          mem_rd_en = 1'b0;
        end
      end
      default: cpu_ready = 1'b0;
    endcase
  end

  // Control state: valid/LRU bits, fill bookkeeping and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r[0]   <= '0;
      valid_r[1]   <= '0;
      lru_r        <= '0;
      victim_r     <= 1'b0;
      fill_index_r <= '0;
      fill_tag_r   <= '0;
      issue_cnt_r  <= '0;
      return_cnt_r <= '0;
      hit_cnt_r    <= '0;
      miss_cnt_r   <= '0;
    end else begin
      if (hit_req_s) begin
        lru_r[index_s] <= ~hit1_s;
        if (hit_cnt_r != '1) hit_cnt_r <= hit_cnt_r + CNT_W'(1);
      end
      if (miss_req_s) begin
        victim_r     <= victim_s;
        fill_index_r <= index_s;
        fill_tag_r   <= tag_s;
        issue_cnt_r  <= '0;
        return_cnt_r <= '0;
        if (miss_cnt_r != '1) miss_cnt_r <= miss_cnt_r + CNT_W'(1);
      end
      if (issuing_s) issue_cnt_r <= issue_cnt_r + (OFFSET_W+1)'(1);
      if (fill_ret_s) begin
        return_cnt_r <= return_cnt_r + OFFSET_W'(1);
        if (fill_done_s) begin
          valid_r[victim_r][fill_index_r] <= 1'b1;
          lru_r[fill_index_r]             <= ~victim_r;
        end
      end
    end
  end

  // Tag array: the victim tag is written only once the whole block has arrived.
  always_ff @(posedge clk) begin
    if (fill_done_s) tag_r[victim_r][fill_index_r] <= fill_tag_r;
  end

  // Data array: hit writes from the CPU, otherwise fill returns into the victim.
  always_ff @(posedge clk) begin
    if (hit_req_s && cpu_wr)
      data_r[{hit1_s, index_s, offset_s}] <= cpu_wdata;
    else if (fill_ret_s)
      data_r[{victim_r, fill_index_r, return_cnt_r}] <= mem_data;
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scoreboard bench for assoc_cache_ctrl: directed accesses push expected
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int ret_seen = 0;

  typedef struct { bit wr; logic [15:0] rdata; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] fill_q[$];
  logic [31:0] wr_q[$];
  logic [16:0] pipe[4] = '{default: 17'h0};

  assoc_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: returns data equal to the word address, four cycles later.
  always @(negedge clk) begin
    mem_data_valid = pipe[3][16];
    mem_data       = pipe[3][15:0];
    if (pipe[3][16]) ret_seen++;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = {mem_rd_en & rst, mem_addr};
  end

  // Monitor: pops scoreboard entries whenever the DUT completes or talks to memory.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] fa;
    logic [31:0] w;
    if (rst) begin
      if (cpu_req && cpu_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 32'(cpu_ready), 32'd0);
        else begin
          e = exp_q.pop_front();
          if (!e.wr) chk("rdata", 32'(cpu_rdata), 32'(e.rdata));
        end
      end
      if (mem_rd_en) begin
        if (fill_q.size() == 0) chk("unexpected_rd", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          fa = fill_q.pop_front();
          chk("fill_addr", 32'(mem_addr), 32'(fa));
        end
      end
      if (mem_wr_en) begin
        chk("wr_needs_ready", 32'(cpu_ready), 32'd1);
        if (wr_q.size() == 0) chk("unexpected_wr", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr_data", {mem_addr, mem_wdata}, w);
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input bit miss);
    exp_t e;
    int   stalls;
    bit   done;
    e.wr = wr;
    e.rdata = exp_rd;
    exp_q.push_back(e);
    if (miss) for (int i = 0; i < 8; i++) fill_q.push_back((a & 16'hFFF0) | 16'(i << 1));
    if (wr) wr_q.push_back({a, wd});
    cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
      else stalls++;
    end
    chk("access_done", 32'(done), 32'd1);
    if (miss) chk("miss_stall", 32'(stalls >= 9), 32'd1);
    else      chk("hit_stall", 32'(stalls), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"},  32'(cpu_ready), 32'd0);
    chk({tag, "_rd_en"},  32'(mem_rd_en), 32'd0);
    chk({tag, "_wr_en"},  32'(mem_wr_en), 32'd0);
    chk({tag, "_maddr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"},  32'(cpu_rdata), 32'd0);
    chk({tag, "_hits"},   32'(hit_cnt),   32'd0);
    chk({tag, "_misses"}, 32'(miss_cnt),  32'd0);
  endtask

  initial begin
    int r0;
    bit seen3;
    rst = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1);
    chk("hits_a", 32'(hit_cnt), 32'd1);
    chk("misses_a", 32'(miss_cnt), 32'd1);
    access(1'b0, 16'h1634, 16'h0000, 16'h1634, 1'b1);
    access(1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0);
    access(1'b0, 16'h1634, 16'h0000, 16'h1634, 1'b0);
    access(1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0);
    access(1'b0, 16'h1A34, 16'h0000, 16'h1A34, 1'b1);
    access(1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0);
    access(1'b0, 16'h1634, 16'h0000, 16'h1634, 1'b1);
    chk("hits_b", 32'(hit_cnt), 32'd8);
    chk("misses_b", 32'(miss_cnt), 32'd4);

    access(1'b1, 16'h1236, 16'hBEEF, 16'h0000, 1'b0);
    access(1'b0, 16'h1236, 16'h0000, 16'hBEEF, 1'b0);
    access(1'b1, 16'h2000, 16'h5A5A, 16'h0000, 1'b1);
    access(1'b0, 16'h2000, 16'h0000, 16'h5A5A, 1'b0);
    access(1'b0, 16'h2002, 16'h0000, 16'h2002, 1'b0);
    chk("hits_c", 32'(hit_cnt), 32'd13);
    chk("misses_c", 32'(miss_cnt), 32'd5);

    // Reset in the middle of a fill, right after the third return is consumed.
    for (int i = 0; i < 8; i++) fill_q.push_back(16'h3450 | 16'(i << 1));
    cpu_wr = 1'b0; cpu_addr = 16'h3456; cpu_req = 1'b1;
    r0 = ret_seen;
    seen3 = 1'b0;
    for (int c = 0; c < 100 && !seen3; c++) begin
      @(posedge clk);
      if (ret_seen - r0 >= 3) seen3 = 1'b1;
    end
    chk("third_return_seen", 32'(seen3), 32'd1);
    #1 rst = 1'b0;
    #1 chk_outputs_zero("midfill_reset");
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    fill_q.delete();
    exp_q.delete();
    wr_q.delete();
    access(1'b0, 16'h3456, 16'h0000, 16'h3456, 1'b1);
    chk("hits_d", 32'(hit_cnt), 32'd1);
    chk("misses_d", 32'(miss_cnt), 32'd1);

    repeat (10) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("fill_q_empty", 32'(fill_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised successor to the direct-mapped L1 cache: a 2-way set-associative, write-through, write-allocate cache with an integrated fill engine, LRU replacement and hit/miss counters.
- Sits between a pipeline memory stage (I- or D-side) and the unified memory model; stalls the pipeline via cpu_ready.
- Tag, valid and LRU state are held in flops; data is a word-addressed array.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width; words are 2-byte aligned, address bit 0 ignored.
- INDEX_W, 6: set-index bits; 2^INDEX_W sets.
- OFFSET_W, 3: word-offset bits; WORDS = 2^OFFSET_W words per block.
- CNT_W, 16: width of the hit/miss counters.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low (Already decided).
- cpu_req, input, 1: access request valid.
- cpu_wr, input, 1: 1 = write, 0 = read.
- cpu_addr, input, ADDR_W: byte address.
- cpu_wdata, input, DATA_W: write data.
- cpu_rdata, output, DATA_W: read data, valid when cpu_ready & ~cpu_wr.
- cpu_ready, output, 1: access completes this cycle; ~cpu_ready is the pipeline stall.
- mem_rd_en, output, 1: memory word read request.
- mem_wr_en, output, 1: memory word write (write-through).
- mem_addr, output, ADDR_W: memory address for the read or write.
- mem_wdata, output, DATA_W: write-through data.
- mem_data_valid, input, 1: returned read word valid; returns arrive in issue order.
- mem_data, input, DATA_W: returned read word.
- hit_cnt, output, CNT_W: saturating count of completed hits.
- miss_cnt, output, CNT_W: saturating count of misses.

Behaviour:
- Address split: offset = addr[OFFSET_W:1]; index = addr[OFFSET_W+INDEX_W:OFFSET_W+1]; tag = the remaining upper bits (TAG_W = ADDR_W-1-OFFSET_W-INDEX_W).
- Lookup is combinational in IDLE. hit_w = valid[w][index] & tag[w][index]==tag; hit = hit0|hit1. Both ways hitting cannot occur.
- States: IDLE, FILL.
- IDLE, cpu_req & hit:
  - cpu_ready = 1 in the same cycle.
  - Read: cpu_rdata = word from the hitting way.
  - Write: the cache word is updated on the clock edge; mem_wr_en = 1, mem_addr = cpu_addr, mem_wdata = cpu_wdata in the same cycle.
  - LRU[index] points to the non-hit way. hit_cnt is incremented.
- IDLE, cpu_req & ~hit:
  - cpu_ready = 0; go to FILL; miss_cnt is incremented once.
  - Victim way = lowest-numbered invalid way; if both ways are valid, victim = LRU[index]. Victim, block base and tag are latched.
- IDLE, ~cpu_req: cpu_ready = 0, no memory activity, no state change.
- FILL:
  - cpu_ready = 0.
  - Issue counter 0..WORDS-1: mem_rd_en = 1 for exactly WORDS consecutive cycles, starting the cycle after entry; mem_addr = base | (issue_cnt<<1).
  - Each mem_data_valid writes mem_data into victim word return_cnt; return_cnt then increments.
  - mem_data_valid arriving after all WORDS returns are received is ignored.
  - On the WORDS-th return: victim tag is written, valid is set, LRU points away from the victim, and the next state is IDLE.
- Completion after a fill: the held request re-looks-up in IDLE, hits, and completes (a write is then written through). That completion counts as a hit.
- mem_wr_en is never asserted in FILL. mem_rd_en is never asserted in IDLE.
- Counters saturate at all-ones and do not wrap.
- cpu_addr/cpu_wr/cpu_wdata must be held stable while cpu_ready = 0. Changing them during FILL is not supported; the fill completes to the latched address regardless.
- Reset (async, rst = 0):
  - State goes to IDLE; all valid and LRU bits, counters and issue/return counters clear.
  - Outputs go to 0: cpu_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, cpu_rdata (cpu_rdata is masked to 0 when not hit).
  - Data array contents are not reset.
  - Reset mid-fill abandons the fill; the partially written way stays invalid.

Test Plan:
- Defaults. After reset, read 0x1234 → miss: mem_rd_en for 8 cycles at 0x1230, 0x1232, …, 0x123E. Memory returns data = address with 4-cycle latency. The cycle after the 8th return, cpu_ready = 1 and cpu_rdata = 0x1234; miss_cnt = 1, hit_cnt = 1.
- Read 0x1634 (same set 0x23, different tag) → fills way 1. Reads of 0x1234 and 0x1634 then both hit with zero stall.
- Read 0x1234 (way 0 becomes MRU), then read 0x1A34 → evicts way 1. Afterwards 0x1234 hits and 0x1634 misses.
- Write 0x1236 = 0xBEEF on a hit → same cycle mem_wr_en = 1, mem_addr = 0x1236, mem_wdata = 0xBEEF, cpu_ready = 1. A later read of 0x1236 returns 0xBEEF.
- Write 0x2000 = 0x5A5A on a miss → 8-word fill with no mem_wr_en during it, then exactly one mem_wr_en at 0x2000. A read of 0x2000 returns 0x5A5A.
- Assert rst low after the 3rd return of a fill → all outputs 0 immediately. Re-reading the same address performs a full 8-word fill; counters restart from 0.
